uart_rx: RTL and testbench

UART receiver that pairs with the team's UART transmitter and sits directly downstream of the serial line.
- Receives 8N1 frames (LSB first, idle-high line) at c_CYCLES_PER_BIT clocks per bit, sampling each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe to the PONG control logic.
- Flags framing errors and rejects glitches shorter than half a bit.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - c_DATA_W                 : payload width of one frame (8 bits)
//   - c_DEFAULT_CYCLES_PER_BIT : default bit period in clocks (50 MHz / 115200)
//   - state_t                  : one-hot receiver FSM state encoding
// The PARITY state is only ever entered when UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int c_DATA_W                 = 8;
   localparam int c_DEFAULT_CYCLES_PER_BIT = 434;

   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      START  = 6'b000010,
      DATA   = 6'b000100,
      PARITY = 6'b001000,
      STOP   = 6'b010000,
      BREAK  = 6'b100000
   } state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing the asynchronous serial line into the i_CLK
// domain. Both flops reset to 1 so the receiver sees an idle line while reset
// is applied and immediately after it is released.
//   i_CLK    : system clock
//   i_RST_N  : asynchronous active-low reset
//   i_ASYNC  : raw asynchronous input
//   o_SYNC   : synchronized copy of i_ASYNC, two cycles later
// -----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic i_CLK,
   input  logic i_RST_N,
   input  logic i_ASYNC,
   output logic o_SYNC
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both flops sample
   // their inputs before either updates; blocking here would collapse the
   // chain into a single flop.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         meta   <= 1'b1;
         o_SYNC <= 1'b1;
      end else begin
         meta   <= i_ASYNC;
         o_SYNC <= meta;
      end
   end

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver (LSB first, idle-high line). Each bit is sampled at its
// mid-point: the start bit is re-checked c_HALF_BIT clocks after its falling
// edge, and every following bit one full bit period later. A start pulse that
// has gone high again by the re-check is treated as a glitch and dropped.
//
// Optional feature (macro UART_RX_PARITY_EN): an even-parity bit is expected
// between the last data bit and the stop bit. A parity mismatch pulses
// o_PARITY_ERR instead of o_RX_DV; a low stop bit still reports o_FRAME_ERR
// and takes precedence over the parity result.
//
// Ports:
//   i_CLK           : system clock, rising edge
//   i_RST_N         : asynchronous active-low reset
//   i_SERIAL_DATA   : asynchronous serial line, idle high
//   o_PARALLEL_DATA : last successfully received byte
//   o_RX_DV         : one-cycle pulse, o_PARALLEL_DATA just updated
//   o_RX_ACTIVE     : high while a frame is being received
//   o_FRAME_ERR     : one-cycle pulse, stop bit sampled low
//   o_PARITY_ERR    : one-cycle pulse, parity mismatch (0 without the option)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
   input  logic                i_CLK,
   input  logic                i_RST_N,
   input  logic                i_SERIAL_DATA,
   output logic [c_DATA_W-1:0] o_PARALLEL_DATA,
   output logic                o_RX_DV,
   output logic                o_RX_ACTIVE,
   output logic                o_FRAME_ERR,
   output logic                o_PARITY_ERR
);

   localparam int          c_HALF_BIT = (c_CYCLES_PER_BIT - 1) / 2;
   localparam logic [31:0] c_HALF_CNT = 32'(c_HALF_BIT);
   localparam logic [31:0] c_LAST_CNT = 32'(c_CYCLES_PER_BIT - 1);

   // Below four clocks per bit the half-bit point collapses onto the edge.
   generate
      if (c_CYCLES_PER_BIT < 4) begin : g_bad_cycles_per_bit
         $error("uart_rx: c_CYCLES_PER_BIT must be >= 4");
      end
   endgenerate

   logic rx_s;

   uart_rx_sync u_sync (
      .i_CLK   (i_CLK),
      .i_RST_N (i_RST_N),
      .i_ASYNC (i_SERIAL_DATA),
      .o_SYNC  (rx_s)
   );

   state_t              state_q,  state_d;
   logic [31:0]         cnt_q,    cnt_d;
   logic [2:0]          idx_q,    idx_d;
   logic [c_DATA_W-1:0] shift_q,  shift_d;
   logic [c_DATA_W-1:0] data_q,   data_d;
   logic                dv_q,     dv_d;
   logic                active_q, active_d;
   logic                fe_q,     fe_d;
`ifdef UART_RX_PARITY_EN
   logic                pe_q,      pe_d;
   logic                par_bad_q, par_bad_d;
`endif

   // NOTE: the shift register is ordinary datapath state, not a memory, so it
   // is reset along with everything else.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         active_q  <= 1'b0;
         fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_q      <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         active_q  <= active_d;
         fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
         pe_q      <= pe_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned (which would infer a latch); pulses default to 0 so
      // they last exactly one cycle.
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      active_d  = active_q;
      dv_d      = 1'b0;
      fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d      = 1'b0;
      par_bad_d = par_bad_q;
`endif

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            if (!rx_s) begin
               state_d  = START;
               active_d = 1'b1;
            end
         end

         START: begin
            if (cnt_q == c_HALF_CNT) begin
               if (!rx_s) begin
                  cnt_d   = '0;
                  state_d = DATA;
               end else begin
                  // Line went high again before mid-start-bit: glitch.
                  state_d  = IDLE;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         DATA: begin
            if (cnt_q == c_LAST_CNT) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = '0;
               if (idx_q != 3'd7) begin
                  idx_d = idx_q + 3'd1;
               end else begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == c_LAST_CNT) begin
               cnt_d = '0;
               // Even parity: data bits plus parity bit hold an even count of 1s.
               par_bad_d = rx_s ^ (^shift_q);
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
`endif

         STOP: begin
            if (cnt_q == c_LAST_CNT) begin
               cnt_d    = '0;
               active_d = 1'b0;
               if (rx_s) begin
                  // Returning to IDLE mid-stop-bit lets a back-to-back start
                  // bit be caught on its falling edge.
                  state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) begin
                     pe_d = 1'b1;
                  end else begin
                     data_d = shift_q;
                     dv_d   = 1'b1;
                  end
`else
                  data_d = shift_q;
                  dv_d   = 1'b1;
`endif
               end else begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         BREAK: begin
            // Hold here while the line stays low so a break reports only once.
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   assign o_PARALLEL_DATA = data_q;
   assign o_RX_DV         = dv_q;
   assign o_RX_ACTIVE     = active_q;
   assign o_FRAME_ERR     = fe_q;
`ifdef UART_RX_PARITY_EN
   assign o_PARITY_ERR    = pe_q;
`else
   assign o_PARITY_ERR    = 1'b0;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 16 clocks per bit. Expected bytes are
// pushed to a scoreboard as frames are driven; a monitor collects every byte
// the receiver strobes out, and each scenario task compares the two.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // Cycle (relative to the first line transition) whose edge samples the
   // stop bit: 2 synchronizer flops + IDLE edge, +1+HALF, +(NB-1) bit periods.
   localparam int STOP_OFF = 3 + 1 + HALF + (NB - 1) * CPB;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       serial = 1'b1;
   logic [7:0] parallel_data;
   logic       rx_dv, rx_active, frame_err, parity_err;
   logic       par_sink;

   uart_rx #(.c_CYCLES_PER_BIT(CPB)) dut (
      .i_CLK           (clk),
      .i_RST_N         (rst_n),
      .i_SERIAL_DATA   (serial),
      .o_PARALLEL_DATA (parallel_data),
      .o_RX_DV         (rx_dv),
      .o_RX_ACTIVE     (rx_active),
      .o_FRAME_ERR     (frame_err),
      .o_PARITY_ERR    (parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int dv_count = 0, fe_count = 0, pe_count = 0;
   int last_dv_cyc = 0, prev_dv_cyc = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_dv) begin
            dv_count++;
            prev_dv_cyc = last_dv_cyc;
            last_dv_cyc = cyc;
            rx_q.push_back(parallel_data);
         end
         if (frame_err)  fe_count++;
         if (parity_err) pe_count++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic sync_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   task automatic send_bit(input logic b);
      serial = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par_b);
`else
      par_sink = par_b;
`endif
      send_bit(stop_b);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      compared++; if (parallel_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h, required 00", parallel_data); end
      compared++; if (rx_dv !== 1'b0)      begin mismatched++; $display("FAIL reset_dv: got %b, required 0", rx_dv); end
      compared++; if (rx_active !== 1'b0)  begin mismatched++; $display("FAIL reset_active: got %b, required 0", rx_active); end
      compared++; if (frame_err !== 1'b0)  begin mismatched++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
      compared++; if (parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_perr: got %b, required 0", parity_err); end
      rst_n = 1'b1;
      repeat (10) sync_edge();
   endtask

   task automatic test_basic();
      int c0, dv0;
      logic act_a, act_b, act_c, act_d;
      logic [7:0] got, want;
      sync_edge();
      c0  = cyc;
      dv0 = dv_count;
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1, ^8'hA5);
         begin
            wait_cyc(c0 + 2);            act_a = rx_active;
            wait_cyc(c0 + 3);            act_b = rx_active;
            wait_cyc(c0 + STOP_OFF - 1); act_c = rx_active;
            wait_cyc(c0 + STOP_OFF);     act_d = rx_active;
         end
      join
      repeat (4) sync_edge();
      compared++; if (act_a !== 1'b0) begin mismatched++; $display("FAIL basic_active_pre: got %b, required 0", act_a); end
      compared++; if (act_b !== 1'b1) begin mismatched++; $display("FAIL basic_active_start: got %b, required 1", act_b); end
      compared++; if (act_c !== 1'b1) begin mismatched++; $display("FAIL basic_active_stop: got %b, required 1", act_c); end
      compared++; if (act_d !== 1'b0) begin mismatched++; $display("FAIL basic_active_end: got %b, required 0", act_d); end
      compared++; if (dv_count - dv0 != 1) begin mismatched++; $display("FAIL basic_dv_count: got %0d, required 1", dv_count - dv0); end
      compared++; if (last_dv_cyc != c0 + STOP_OFF) begin mismatched++; $display("FAIL basic_dv_cycle: got %0d, required %0d", last_dv_cyc - c0, STOP_OFF); end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         compared++; if (got !== want) begin mismatched++; $display("FAIL basic_byte: got %h, required %h", got, want); end
      end
      compared++; if (parallel_data !== 8'hA5) begin mismatched++; $display("FAIL basic_hold: got %h, required a5", parallel_data); end
   endtask

   task automatic test_back_to_back();
      int dv0;
      logic [7:0] got, want;
      sync_edge();
      dv0 = dv_count;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1, ^8'h00);
      send_frame(8'hFF, 1'b1, ^8'hFF);
      repeat (4) sync_edge();
      compared++; if (dv_count - dv0 != 2) begin mismatched++; $display("FAIL b2b_dv_count: got %0d, required 2", dv_count - dv0); end
      compared++; if (last_dv_cyc - prev_dv_cyc != NB * CPB) begin mismatched++; $display("FAIL b2b_spacing: got %0d, required %0d", last_dv_cyc - prev_dv_cyc, NB * CPB); end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         compared++; if (got !== want) begin mismatched++; $display("FAIL b2b_byte: got %h, required %h", got, want); end
      end
   endtask

   task automatic test_glitch();
      int dv0, fe0;
      sync_edge();
      dv0 = dv_count;
      fe0 = fe_count;
      serial = 1'b0;
      repeat (5) sync_edge();
      serial = 1'b1;
      repeat (40) sync_edge();
      compared++; if (dv_count != dv0) begin mismatched++; $display("FAIL glitch_dv: got %0d pulses, required 0", dv_count - dv0); end
      compared++; if (fe_count != fe0) begin mismatched++; $display("FAIL glitch_ferr: got %0d pulses, required 0", fe_count - fe0); end
      compared++; if (parallel_data !== 8'hFF) begin mismatched++; $display("FAIL glitch_data: got %h, required ff", parallel_data); end
      compared++; if (rx_active !== 1'b0) begin mismatched++; $display("FAIL glitch_active: got %b, required 0", rx_active); end
   endtask

   task automatic test_frame_err();
      int dv0, fe0;
      logic [7:0] got, want;
      sync_edge();
      dv0 = dv_count;
      fe0 = fe_count;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      repeat (50 - CPB) sync_edge();
      serial = 1'b1;
      repeat (30) sync_edge();
      compared++; if (fe_count - fe0 != 1) begin mismatched++; $display("FAIL ferr_count: got %0d, required 1", fe_count - fe0); end
      compared++; if (dv_count != dv0) begin mismatched++; $display("FAIL ferr_dv: got %0d pulses, required 0", dv_count - dv0); end
      compared++; if (parallel_data !== 8'hFF) begin mismatched++; $display("FAIL ferr_data: got %h, required ff", parallel_data); end
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, ^8'h11);
      repeat (4) sync_edge();
      compared++; if (dv_count - dv0 != 1) begin mismatched++; $display("FAIL ferr_next_dv: got %0d, required 1", dv_count - dv0); end
      compared++; if (fe_count - fe0 != 1) begin mismatched++; $display("FAIL ferr_next_ferr: got %0d, required 1", fe_count - fe0); end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         compared++; if (got !== want) begin mismatched++; $display("FAIL ferr_next_byte: got %h, required %h", got, want); end
      end
   endtask

   task automatic test_reset_mid();
      int dv0, fe0;
      logic [7:0] d;
      logic [7:0] got, want;
      d = 8'h5A;
      sync_edge();
      dv0 = dv_count;
      fe0 = fe_count;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      serial = d[4];
      repeat (CPB / 2) sync_edge();
      rst_n = 1'b0;
      #1;
      compared++; if (rx_active !== 1'b0) begin mismatched++; $display("FAIL rstmid_active: got %b, required 0", rx_active); end
      compared++; if (parallel_data !== 8'h00) begin mismatched++; $display("FAIL rstmid_data: got %h, required 00", parallel_data); end
      compared++; if ({rx_dv, frame_err, parity_err} !== 3'b000) begin mismatched++; $display("FAIL rstmid_pulses: got %b, required 000", {rx_dv, frame_err, parity_err}); end
      serial = 1'b1;
      repeat (5) sync_edge();
      rst_n = 1'b1;
      repeat (10 * CPB) sync_edge();
      compared++; if (dv_count != dv0 || fe_count != fe0) begin mismatched++; $display("FAIL rstmid_no_pulse: got dv %0d ferr %0d, required 0 0", dv_count - dv0, fe_count - fe0); end
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, ^8'h81);
      repeat (4) sync_edge();
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         compared++; if (got !== want) begin mismatched++; $display("FAIL rstmid_next_byte: got %h, required %h", got, want); end
      end
      compared++; if (parallel_data !== 8'h81) begin mismatched++; $display("FAIL rstmid_next_data: got %h, required 81", parallel_data); end
   endtask

   task automatic test_parity();
`ifdef UART_RX_PARITY_EN
      int dv0, pe0;
      logic [7:0] got, want;
      sync_edge();
      dv0 = dv_count;
      pe0 = pe_count;
      send_frame(8'h07, 1'b1, 1'b0);
      repeat (4) sync_edge();
      compared++; if (pe_count - pe0 != 1) begin mismatched++; $display("FAIL parity_bad_perr: got %0d, required 1", pe_count - pe0); end
      compared++; if (dv_count != dv0) begin mismatched++; $display("FAIL parity_bad_dv: got %0d, required 0", dv_count - dv0); end
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (4) sync_edge();
      compared++; if (pe_count - pe0 != 1) begin mismatched++; $display("FAIL parity_good_perr: got %0d, required 1", pe_count - pe0); end
      compared++; if (dv_count - dv0 != 1) begin mismatched++; $display("FAIL parity_good_dv: got %0d, required 1", dv_count - dv0); end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         compared++; if (got !== want) begin mismatched++; $display("FAIL parity_good_byte: got %h, required %h", got, want); end
      end
`else
      sync_edge();
      compared++; if (pe_count != 0) begin mismatched++; $display("FAIL parity_off_pulses: got %0d, required 0", pe_count); end
      compared++; if (parity_err !== 1'b0) begin mismatched++; $display("FAIL parity_off_level: got %b, required 0", parity_err); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_parity();
      compared++;
      if (rx_q.size() != 0) begin
         mismatched++;
         $display("FAIL unexpected_bytes: got %0d extra, required 0", rx_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_uart_rx
